rng_wb_initiator: RTL and testbench
===================================

Name: rng_wb_initiator

Overview:
- Wishbone classic initiator that drives the PCG random-number responder from the management side.
- Accepts a configuration command, optionally writes seed words, then issues a programmed number of single reads from the output word.
- Buffers returned words in a small FIFO and presents them on a valid/ready stream.
- Sits between firmware/LA control logic and the responder's Wishbone slave port; it is the initiator for that responder.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- TIMEOUT, 15, max cycles stb may wait for ack before abort (≥1)
- CNT_W, 16, width of read-count field

Ports:
- clk  in  1  single clock; responder's wb_clk_i domain
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  command request
- cfg_ready  out  1  high only in IDLE
- cfg_seed_load  in  1  write cfg_seed before reading
- cfg_seed  in  64  seed value
- cfg_count  in  CNT_W  number of reads to perform
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pop
- out_data  out  32  FIFO head word
- wb_cyc_o / wb_stb_o  out  1 each  bus request (always equal)
- wb_we_o  out  1  write strobe
- wb_sel_o  out  4  always 4'hF during a cycle, 0 otherwise
- wb_adr_o  out  32  word index: 0 output, 1 seed hi, 2 seed lo, 3/4 mult hi/lo, 5/6 inc hi/lo
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  responder ack
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): all outputs 0 except cfg_ready=1. FIFO empty; state IDLE; err=0.
- Handshake: cfg accepted at cycle T when cfg_valid & cfg_ready. Fields are latched. err clears at T. First bus cycle has cyc/stb high at T+1.
- FSM states: IDLE, WR_SEED_HI, WR_SEED_LO, (optional WR_M_HI/LO, WR_I_HI/LO), RD, DONE.
  - IDLE -> WR_SEED_HI if seed_load, else -> RD.
  - Write states go in address order, one bus cycle each.
  - RD loops until the remaining count is 0, then DONE. DONE -> IDLE the next cycle.
- Bus cycle: cyc/stb/adr/we/dat/sel are stable from assertion until the cycle in which wb_ack_i=1. They drop the cycle after ack, leaving a minimum one-cycle idle gap between transactions. wb_ack_i outside a cycle is ignored.
- Reads: a read starts only if the FIFO has a free slot, so at most one read is outstanding. On ack, wb_dat_i is pushed; out_valid is seen at the earliest one cycle after ack. Data is delivered in issue order.
- FIFO: pop when out_valid & out_ready.
  - Full: no read is issued; RD stalls with cyc low.
  - Pop while full, same cycle a read could start: the read starts the next cycle.
  - Simultaneous push and pop when non-empty keeps occupancy unchanged.
- Count:
  - cfg_count=0: writes (if any) are done, no reads, then DONE.
  - The remaining counter decrements on each read ack and never wraps below 0.
- Timeout: a per-cycle counter starts at stb assertion.
  - If TIMEOUT cycles pass with no ack, drop cyc/stb, set err=1, discard the remaining count and pending writes, and go to IDLE.
  - FIFO contents are retained.
- Reset mid-transaction: cyc/stb drop asynchronously and the FIFO is flushed.

Optional Feature:
- Macro RNG_INIT_MULT_LOAD_EN.
- Defined:
  - Adds input ports cfg_mult_load (1), cfg_mult (64), cfg_inc (64).
  - When cfg_mult_load=1, after the seed writes (or directly from IDLE) the block writes addresses 3, 4, 5, 6 with mult hi/lo and inc hi/lo, then enters RD.
- Undefined: these ports and states are absent; only addresses 0–2 are ever driven.

Decomposition:
- Package rng_wb_pkg contains:
  - Address constants ADR_OUT=0, ADR_SEED_HI=1 … ADR_INC_LO=6.
  - FSM state enum.
  - Default constants SEED_DEF=64'h123456789abcdef0, MULT_DEF=64'h5851f42d4c957f2d, INC_DEF=64'h14057b7ef767814f (for the bench).
- One sub-module: rng_sync_fifo (DEPTH x 32, async active-low reset, full/empty flags).

Test Plan:
- Reset, then cfg seed_load=1, seed=64'h0000000100000002, count=3, responder acks after 1 cycle -> writes adr1=32'h1, adr2=32'h2, then 3 reads of adr0. out stream returns those 3 words in order; err=0, busy falls.
- count=0, seed_load=0 -> no wb_cyc_o assertion; busy high exactly 2 cycles (RD→DONE→IDLE).
- count=8, DEPTH=4, out_ready=0 -> exactly 4 reads, then cyc stays low. Raising out_ready drains all 8 words; no read is issued while the FIFO is full.
- Responder never acks, count=2 -> cyc high for exactly 15 cycles, then drops; err=1, cfg_ready=1. The next accepted cfg clears err.
- rst_n pulsed low while stb is high mid-read -> cyc/stb/out_valid go 0 in the same cycle; after release the block is in IDLE with the FIFO empty.
- With RNG_INIT_MULT_LOAD_EN defined, cfg_mult_load=1 using the default constants -> adr3..6 written with 5851f42d, 4c957f2d, 14057b7e, f767814f, then reads proceed.

Source files
------------

// File: rtl/rng_wb_pkg.sv
// Shared definitions for the PCG responder Wishbone initiator.
// Optional build macro: RNG_INIT_MULT_LOAD_EN (adds multiplier/increment writes).
package rng_wb_pkg;

   localparam int unsigned WB_AW  = 32;
   localparam int unsigned WB_DW  = 32;
   localparam int unsigned SEED_W = 64;

   // Responder word map
   localparam logic [WB_AW-1:0] ADR_OUT     = 32'd0;
   localparam logic [WB_AW-1:0] ADR_SEED_HI = 32'd1;
   localparam logic [WB_AW-1:0] ADR_SEED_LO = 32'd2;
   localparam logic [WB_AW-1:0] ADR_MULT_HI = 32'd3;
   localparam logic [WB_AW-1:0] ADR_MULT_LO = 32'd4;
   localparam logic [WB_AW-1:0] ADR_INC_HI  = 32'd5;
   localparam logic [WB_AW-1:0] ADR_INC_LO  = 32'd6;

   // Responder power-on constants
   localparam logic [SEED_W-1:0] SEED_DEF = 64'h123456789abcdef0;
   localparam logic [SEED_W-1:0] MULT_DEF = 64'h5851f42d4c957f2d;
   localparam logic [SEED_W-1:0] INC_DEF  = 64'h14057b7ef767814f;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_WR_SEED_HI = 4'd1,
      ST_WR_SEED_LO = 4'd2,
`ifdef RNG_INIT_MULT_LOAD_EN
      ST_WR_M_HI    = 4'd3,
      ST_WR_M_LO    = 4'd4,
      ST_WR_I_HI    = 4'd5,
      ST_WR_I_LO    = 4'd6,
`endif
      ST_RD         = 4'd7,
      ST_DONE       = 4'd8
   } rng_state_e;

endpackage

// File: rtl/rng_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags and async flush on reset.
module rng_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Occupancy after this cycle's push/pop
   always_comb begin
      cnt_n = cnt;
      case ({do_push, do_pop})
         2'b10:   cnt_n = cnt + CW'(1);
         2'b01:   cnt_n = cnt - CW'(1);
         default: cnt_n = cnt;
      endcase
   end

   // Pointers, count and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt   <= cnt_n;
         full  <= (cnt_n == CW'(DEPTH));
         empty <= (cnt_n == '0);
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rng_wb_initiator.sv
// Wishbone classic initiator for the PCG responder: optional seed (and, with
// RNG_INIT_MULT_LOAD_EN, multiplier/increment) writes followed by counted reads
// of the output word, buffered into a valid/ready stream.
module rng_wb_initiator
   import rng_wb_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_seed_load,
   input  logic [63:0]      cfg_seed,
   input  logic [CNT_W-1:0] cfg_count,
`ifdef RNG_INIT_MULT_LOAD_EN
   input  logic             cfg_mult_load,
   input  logic [63:0]      cfg_mult,
   input  logic [63:0]      cfg_inc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [3:0]       wb_sel_o,
   output logic [31:0]      wb_adr_o,
   output logic [31:0]      wb_dat_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   output logic             busy,
   output logic             err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   rng_state_e       state_q, state_n, wr_after;
   logic             cyc_q, cyc_n;
   logic             we_q;
   logic [3:0]       sel_q;
   logic [31:0]      adr_q, dat_q;
   logic [TMO_W-1:0] tmo_q, tmo_n;
   logic [CNT_W-1:0] rem_q, rem_n;
   logic [63:0]      seed_q, seed_v;
   logic             err_q, err_n;
   logic             busy_q, cfg_ready_q;
   logic             launch, push, pop, is_wr, rd_free;
   logic             fifo_full, fifo_empty;
   logic             req_we;
   logic [31:0]      req_adr, req_dat;
`ifdef RNG_INIT_MULT_LOAD_EN
   logic             mload_q;
   logic [63:0]      mult_q, inc_q, mult_v, inc_v;
`endif

   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_sel_o  = sel_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign cfg_ready = cfg_ready_q;
   assign out_valid = ~fifo_empty;

   // A pop this cycle frees a slot in time for a read launched at this edge
   assign pop     = out_valid & out_ready;
   assign rd_free = ~fifo_full | pop;

   // Command fields come straight from the inputs on the accept cycle
   assign seed_v = (state_q == ST_IDLE) ? cfg_seed : seed_q;
`ifdef RNG_INIT_MULT_LOAD_EN
   assign mult_v = (state_q == ST_IDLE) ? cfg_mult : mult_q;
   assign inc_v  = (state_q == ST_IDLE) ? cfg_inc  : inc_q;
`endif

   // Next state, bus launch/retire, watchdog and count
   always_comb begin
      state_n  = state_q;
      cyc_n    = cyc_q;
      tmo_n    = tmo_q;
      rem_n    = rem_q;
      err_n    = err_q;
      launch   = 1'b0;
      push     = 1'b0;
      is_wr    = 1'b0;
      wr_after = ST_RD;

      case (state_q)
         ST_WR_SEED_HI: begin is_wr = 1'b1; wr_after = ST_WR_SEED_LO; end
`ifdef RNG_INIT_MULT_LOAD_EN
         ST_WR_SEED_LO: begin is_wr = 1'b1; wr_after = mload_q ? ST_WR_M_HI : ST_RD; end
         ST_WR_M_HI:    begin is_wr = 1'b1; wr_after = ST_WR_M_LO; end
         ST_WR_M_LO:    begin is_wr = 1'b1; wr_after = ST_WR_I_HI; end
         ST_WR_I_HI:    begin is_wr = 1'b1; wr_after = ST_WR_I_LO; end
         ST_WR_I_LO:    begin is_wr = 1'b1; wr_after = ST_RD; end
`else
         ST_WR_SEED_LO: begin is_wr = 1'b1; wr_after = ST_RD; end
`endif
         default: ;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               err_n = 1'b0;
               rem_n = cfg_count;
               if (cfg_seed_load) begin
                  state_n = ST_WR_SEED_HI;
                  launch  = 1'b1;
               end
`ifdef RNG_INIT_MULT_LOAD_EN
               else if (cfg_mult_load) begin
                  state_n = ST_WR_M_HI;
                  launch  = 1'b1;
               end
`endif
               else begin
                  state_n = ST_RD;
                  launch  = (cfg_count != '0) && rd_free;
               end
            end
         end
         ST_RD: begin
            if (!cyc_q) begin
               if (rem_q == '0)  state_n = ST_DONE;
               else if (rd_free) launch  = 1'b1;
            end else if (wb_ack_i) begin
               cyc_n = 1'b0;
               push  = 1'b1;
               if (rem_q != '0) rem_n = rem_q - CNT_W'(1);
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: begin
            if (is_wr) begin
               if (!cyc_q) begin
                  launch = 1'b1;
               end else if (wb_ack_i) begin
                  cyc_n   = 1'b0;
                  state_n = wr_after;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
      endcase

      // Abort an unanswered cycle and drop everything still queued
      if (cyc_q && !wb_ack_i) begin
         if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            cyc_n   = 1'b0;
            err_n   = 1'b1;
            rem_n   = '0;
            state_n = ST_IDLE;
         end else begin
            tmo_n = tmo_q + TMO_W'(1);
         end
      end

      if (launch) begin
         cyc_n = 1'b1;
         tmo_n = '0;
      end
   end

   // Address/data of the bus cycle for the state being entered
   always_comb begin
      req_we  = 1'b1;
      req_adr = ADR_OUT;
      req_dat = '0;
      case (state_n)
         ST_WR_SEED_HI: begin req_adr = ADR_SEED_HI; req_dat = seed_v[63:32]; end
         ST_WR_SEED_LO: begin req_adr = ADR_SEED_LO; req_dat = seed_v[31:0];  end
`ifdef RNG_INIT_MULT_LOAD_EN
         ST_WR_M_HI:    begin req_adr = ADR_MULT_HI; req_dat = mult_v[63:32]; end
         ST_WR_M_LO:    begin req_adr = ADR_MULT_LO; req_dat = mult_v[31:0];  end
         ST_WR_I_HI:    begin req_adr = ADR_INC_HI;  req_dat = inc_v[63:32];  end
         ST_WR_I_LO:    begin req_adr = ADR_INC_LO;  req_dat = inc_v[31:0];   end
`endif
         default:       req_we = 1'b0;
      endcase
   end

   // State, registered bus outputs and latched command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         tmo_q       <= '0;
         rem_q       <= '0;
         seed_q      <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
`ifdef RNG_INIT_MULT_LOAD_EN
         mload_q     <= 1'b0;
         mult_q      <= '0;
         inc_q       <= '0;
`endif
      end else begin
         state_q     <= state_n;
         cyc_q       <= cyc_n;
         tmo_q       <= tmo_n;
         rem_q       <= rem_n;
         err_q       <= err_n;
         busy_q      <= (state_n != ST_IDLE);
         cfg_ready_q <= (state_n == ST_IDLE);
         sel_q       <= cyc_n ? 4'hF : 4'h0;
         if (state_q == ST_IDLE && cfg_valid) begin
            seed_q  <= cfg_seed;
`ifdef RNG_INIT_MULT_LOAD_EN
            mload_q <= cfg_mult_load;
            mult_q  <= cfg_mult;
            inc_q   <= cfg_inc;
`endif
         end
         if (launch) begin
            we_q  <= req_we;
            adr_q <= req_adr;
            dat_q <= req_dat;
         end else if (!cyc_n) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
         end
      end
   end

   rng_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wb_dat_i),
      .pop   (pop),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_rng_wb_initiator.sv
// Directed bench for rng_wb_initiator with a simple acking responder model.
module tb_rng_wb_initiator;
   import rng_wb_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic             cfg_seed_load = 1'b0;
   logic [63:0]      cfg_seed = '0;
   logic [CNT_W-1:0] cfg_count = '0;
`ifdef RNG_INIT_MULT_LOAD_EN
   logic             cfg_mult_load = 1'b0;
   logic [63:0]      cfg_mult = '0;
   logic [63:0]      cfg_inc = '0;
`endif
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic             wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]       wb_sel_o;
   logic [31:0]      wb_adr_o, wb_dat_o;
   logic [31:0]      wb_dat_i = '0;
   logic             wb_ack_i = 1'b0;
   logic             busy, err;

   int checks = 0;
   int failures = 0;

   rng_wb_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_seed_load(cfg_seed_load),
      .cfg_seed(cfg_seed), .cfg_count(cfg_count),
`ifdef RNG_INIT_MULT_LOAD_EN
      .cfg_mult_load(cfg_mult_load), .cfg_mult(cfg_mult), .cfg_inc(cfg_inc),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Responder model, stream collector and bus monitors
   logic        ack_en = 1'b1;
   int          ack_lat = 1;
   int          wcnt = 0;
   int          rd_n = 0;
   int          cyc_cyc = 0, busy_cyc = 0, cyc_rise = 0, proto_err = 0;
   int          occ = 0, max_occ = 0;
   logic        prev_cyc = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_adr = '0, prev_dat = '0;
   logic [31:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic        log_we[$];
   logic [31:0] got_q[$];

   always @(negedge clk) begin
      if (wb_ack_i && wb_cyc_o) proto_err++;
      if (wb_cyc_o && prev_cyc && !wb_ack_i &&
          (wb_adr_o !== prev_adr || wb_dat_o !== prev_dat || wb_we_o !== prev_we)) proto_err++;
      if (wb_stb_o !== wb_cyc_o) proto_err++;
      if (wb_sel_o !== (wb_cyc_o ? 4'hF : 4'h0)) proto_err++;
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back(out_data);
         occ--;
      end
      if (busy) busy_cyc++;
      if (wb_cyc_o) cyc_cyc++;
      if (wb_cyc_o && !prev_cyc) cyc_rise++;
      if (wb_cyc_o) begin
         wcnt++;
         if (ack_en && wcnt == ack_lat) begin
            wb_ack_i = 1'b1;
            log_adr.push_back(wb_adr_o);
            log_dat.push_back(wb_dat_o);
            log_we.push_back(wb_we_o);
            if (!wb_we_o) begin
               wb_dat_i = 32'hC0DE_0000 + 32'(rd_n);
               rd_n++;
               occ++;
            end
         end else begin
            wb_ack_i = 1'b0;
         end
      end else begin
         wcnt = 0;
         wb_ack_i = 1'b0;
      end
      if (!rst_n) occ = 0;
      if (occ > max_occ) max_occ = occ;
      prev_cyc = wb_cyc_o;
      prev_adr = wb_adr_o;
      prev_dat = wb_dat_o;
      prev_we  = wb_we_o;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_cfg(input logic sl, input logic [63:0] seed, input logic [CNT_W-1:0] cnt);
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_seed_load = sl; cfg_seed = seed; cfg_count = cnt;
      @(posedge clk); #1;
      cfg_valid = 1'b0; cfg_seed_load = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%0h exp=1", cfg_ready); end
      checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL rst_cyc got=%0h exp=0", wb_cyc_o); end
      checks++; if (wb_sel_o !== 4'h0) begin failures++; $display("FAIL rst_sel got=%0h exp=0", wb_sel_o); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", err); end
      #10 rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_seed_read();
      int  l0, g0, b0;
      bit  ok;
      logic [31:0] exp_adr [5];
      logic [31:0] exp_dat [5];
      logic        exp_we  [5];
      exp_adr = '{32'd1, 32'd2, 32'd0, 32'd0, 32'd0};
      exp_dat = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h0};
      exp_we  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      l0 = log_adr.size(); g0 = got_q.size(); b0 = rd_n;
      ack_lat = 2; out_ready = 1'b1;
      send_cfg(1'b1, 64'h0000_0001_0000_0002, 16'd3);
      checks++; if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== {1'b1, 1'b1, 32'd1, 32'd1})
         begin failures++; $display("FAIL seed_first_cycle got=%0h/%0h/%0h/%0h exp=1/1/1/1", wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o); end
      wait_idle(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL seed_idle_timeout busy=%0h exp=0", busy); end
      repeat (3) @(negedge clk);
      checks++; if (log_adr.size() - l0 != 5) begin failures++; $display("FAIL seed_txn_count got=%0d exp=5", log_adr.size() - l0); end
      for (int i = 0; i < 5; i++) begin
         if (l0 + i < log_adr.size()) begin
            checks++;
            if (log_adr[l0+i] !== exp_adr[i] || log_we[l0+i] !== exp_we[i] ||
                (exp_we[i] && log_dat[l0+i] !== exp_dat[i])) begin
               failures++;
               $display("FAIL seed_txn%0d got adr=%0h we=%0h dat=%0h exp adr=%0h we=%0h dat=%0h",
                        i, log_adr[l0+i], log_we[l0+i], log_dat[l0+i], exp_adr[i], exp_we[i], exp_dat[i]);
            end
         end
      end
      checks++; if (got_q.size() - g0 != 3) begin failures++; $display("FAIL seed_words got=%0d exp=3", got_q.size() - g0); end
      for (int i = 0; i < 3; i++) begin
         if (g0 + i < got_q.size()) begin
            checks++;
            if (got_q[g0+i] !== 32'hC0DE_0000 + 32'(b0 + i)) begin
               failures++; $display("FAIL seed_word%0d got=%h exp=%h", i, got_q[g0+i], 32'hC0DE_0000 + 32'(b0 + i));
            end
         end
      end
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL seed_end_flags got err=%0h busy=%0h exp 0/0", err, busy); end
   endtask

   task automatic test_count_zero();
      int b0, c0, r0;
      b0 = busy_cyc; c0 = cyc_cyc; r0 = cyc_rise;
      send_cfg(1'b0, 64'h0, 16'd0);
      repeat (6) @(negedge clk);
      checks++; if (busy_cyc - b0 != 2) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=2", busy_cyc - b0); end
      checks++; if (cyc_rise - r0 != 0 || cyc_cyc - c0 != 0) begin failures++; $display("FAIL zero_no_bus got rises=%0d exp=0", cyc_rise - r0); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_cfg_ready got=%0h exp=1", cfg_ready); end
   endtask

   task automatic test_fifo_full();
      int  l0, g0, b0;
      bit  ok;
      l0 = log_adr.size(); g0 = got_q.size(); b0 = rd_n;
      ack_lat = 1; out_ready = 1'b0;
      send_cfg(1'b0, 64'h0, 16'd8);
      repeat (60) @(negedge clk);
      checks++; if (log_adr.size() - l0 != 4) begin failures++; $display("FAIL full_reads got=%0d exp=4", log_adr.size() - l0); end
      checks++; if (wb_cyc_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL full_stall got cyc=%0h busy=%0h exp 0/1", wb_cyc_o, busy); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid got=%0h exp=1", out_valid); end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_idle(300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL full_idle_timeout busy=%0h exp=0", busy); end
      repeat (4) @(negedge clk);
      checks++; if (got_q.size() - g0 != 8) begin failures++; $display("FAIL full_words got=%0d exp=8", got_q.size() - g0); end
      for (int i = 0; i < 8; i++) begin
         if (g0 + i < got_q.size()) begin
            checks++;
            if (got_q[g0+i] !== 32'hC0DE_0000 + 32'(b0 + i)) begin
               failures++; $display("FAIL full_word%0d got=%h exp=%h", i, got_q[g0+i], 32'hC0DE_0000 + 32'(b0 + i));
            end
         end
      end
      checks++; if (max_occ != 4) begin failures++; $display("FAIL full_max_occupancy got=%0d exp=4", max_occ); end
   endtask

   task automatic test_timeout();
      int  c0, r0;
      bit  ok;
      c0 = cyc_cyc; r0 = cyc_rise;
      ack_en = 1'b0; out_ready = 1'b1;
      send_cfg(1'b0, 64'h0, 16'd2);
      wait_idle(60, ok);
      checks++; if (!ok) begin failures++; $display("FAIL tmo_idle_timeout busy=%0h exp=0", busy); end
      repeat (3) @(negedge clk);
      checks++; if (cyc_cyc - c0 != 15) begin failures++; $display("FAIL tmo_cyc_cycles got=%0d exp=15", cyc_cyc - c0); end
      checks++; if (cyc_rise - r0 != 1) begin failures++; $display("FAIL tmo_cycles_issued got=%0d exp=1", cyc_rise - r0); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0h exp=1", err); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL tmo_cfg_ready got=%0h exp=1", cfg_ready); end
      ack_en = 1'b1;
      send_cfg(1'b0, 64'h0, 16'd0);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_clear got=%0h exp=0", err); end
      wait_idle(20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL tmo_clear_idle busy=%0h exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int  g0, b0;
      bit  ok;
      g0 = got_q.size(); b0 = rd_n;
      ack_lat = 1; out_ready = 1'b1;
      send_cfg(1'b0, 64'h0, 16'd2);
      wait_idle(100, ok);
      send_cfg(1'b0, 64'h0, 16'd2);
      wait_idle(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_idle_timeout busy=%0h exp=0", busy); end
      repeat (3) @(negedge clk);
      checks++; if (got_q.size() - g0 != 4) begin failures++; $display("FAIL b2b_words got=%0d exp=4", got_q.size() - g0); end
      for (int i = 0; i < 4; i++) begin
         if (g0 + i < got_q.size()) begin
            checks++;
            if (got_q[g0+i] !== 32'hC0DE_0000 + 32'(b0 + i)) begin
               failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[g0+i], 32'hC0DE_0000 + 32'(b0 + i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      ack_lat = 1; out_ready = 1'b0;
      send_cfg(1'b0, 64'h0, 16'd2);
      wait_idle(100, ok);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_preload got=%0h exp=1", out_valid); end
      ack_en = 1'b0;
      send_cfg(1'b0, 64'h0, 16'd1);
      repeat (3) @(negedge clk);
      checks++; if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL rstmid_cyc_before got=%0h exp=1", wb_cyc_o); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({wb_cyc_o, wb_stb_o, out_valid} !== 3'b000) begin failures++; $display("FAIL rstmid_async got=%b exp=000", {wb_cyc_o, wb_stb_o, out_valid}); end
      @(negedge clk); #2 rst_n = 1'b1;
      ack_en = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({cfg_ready, busy, out_valid, wb_cyc_o} !== 4'b1000) begin failures++; $display("FAIL rstmid_after got=%b exp=1000", {cfg_ready, busy, out_valid, wb_cyc_o}); end
   endtask

`ifdef RNG_INIT_MULT_LOAD_EN
   task automatic test_mult_load();
      int  l0;
      bit  ok;
      logic [31:0] exp_adr [5];
      logic [31:0] exp_dat [5];
      exp_adr = '{32'd3, 32'd4, 32'd5, 32'd6, 32'd0};
      exp_dat = '{32'h5851f42d, 32'h4c957f2d, 32'h14057b7e, 32'hf767814f, 32'h0};
      l0 = log_adr.size();
      ack_lat = 1; out_ready = 1'b1;
      cfg_mult_load = 1'b1; cfg_mult = MULT_DEF; cfg_inc = INC_DEF;
      send_cfg(1'b0, 64'h0, 16'd1);
      cfg_mult_load = 1'b0;
      wait_idle(100, ok);
      checks++; if (log_adr.size() - l0 != 5) begin failures++; $display("FAIL mult_txn_count got=%0d exp=5", log_adr.size() - l0); end
      for (int i = 0; i < 5; i++) begin
         if (l0 + i < log_adr.size()) begin
            checks++;
            if (log_adr[l0+i] !== exp_adr[i] || (i < 4 && log_dat[l0+i] !== exp_dat[i])) begin
               failures++; $display("FAIL mult_txn%0d got adr=%0h dat=%h exp adr=%0h dat=%h", i, log_adr[l0+i], log_dat[l0+i], exp_adr[i], exp_dat[i]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_seed_read();
      test_count_zero();
      test_fifo_full();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
`ifdef RNG_INIT_MULT_LOAD_EN
      test_mult_load();
`endif
      checks++; if (proto_err != 0) begin failures++; $display("FAIL bus_protocol got=%0d violations exp=0", proto_err); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
